// File: rtl/debounced_hex_counter.sv
// Two raw push buttons -> synchronize, debounce, detect press edge -> wrapping
// up/down count (0..MAX_COUNT) with a one-cycle strobe on every count change.
module debounced_hex_counter #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int MAX_COUNT      = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_Switch_Up,
  input  logic       i_Switch_Down,
  output logic [3:0] o_Count,
  output logic       o_Count_Pulse,
  output logic       o_Up_Debounced,
  output logic       o_Down_Debounced
);

  localparam int         NUM_BTN    = 2;
  localparam int         CNT_W      = 20;
  localparam logic [CNT_W-1:0] C_LIMIT_M1 = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [3:0] C_MAX      = 4'(MAX_COUNT);

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_stable;
  logic [NUM_BTN-1:0] r_stable_q;
  logic [CNT_W-1:0]   r_db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] w_press;

  logic [3:0] r_count;
  logic       r_pulse;
  logic [3:0] w_count_next;
  logic       w_pulse_next;

  assign w_raw = {i_Switch_Down, i_Switch_Up};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      for (int i = 0; i < NUM_BTN; i++) begin
        // Any cycle that agrees with the accepted level restarts the filter.
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == C_LIMIT_M1) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_press
      assign w_press[gi] = r_stable[gi] & ~r_stable_q[gi];
    end
  endgenerate

  always_comb begin
    w_count_next = r_count;
    w_pulse_next = 1'b0;
    case (w_press)
      2'b01: begin
        w_count_next = (r_count == C_MAX) ? 4'd0 : r_count + 4'd1;
        w_pulse_next = 1'b1;
      end
      2'b10: begin
        w_count_next = (r_count == 4'd0) ? C_MAX : r_count - 4'd1;
        w_pulse_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_pulse <= w_pulse_next;
    end
  end

  assign o_Count          = r_count;
  assign o_Count_Pulse    = r_pulse;
  assign o_Up_Debounced   = r_stable[0];
  assign o_Down_Debounced = r_stable[1];

endmodule
